// File: rtl/encrypt_seq_ctrl_pkg.sv
// Shared definitions for the encap encryption sequencer: McEliece parameter-set
// tables, derived stream sizes and the sequencer state encoding.
package encrypt_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_RDY,
        ST_STREAM,
        ST_WAIT_DONE,
        ST_READOUT
    } seq_state_t;

    localparam int CIPHER_WORD_W = 32;

    function automatic int set_n(input int ps);
        case (ps)
            1:       return 3488;
            2:       return 4608;
            3:       return 6688;
            4:       return 6960;
            default: return 8192;
        endcase
    endfunction

    function automatic int set_m(input int ps);
        return (ps == 1) ? 12 : 13;
    endfunction

    function automatic int set_t(input int ps);
        case (ps)
            1:       return 64;
            2:       return 96;
            3:       return 128;
            4:       return 119;
            default: return 128;
        endcase
    endfunction

    function automatic int calc_l(input int ps);
        return set_m(ps) * set_t(ps);
    endfunction

    function automatic int calc_k(input int ps);
        return set_n(ps) - calc_l(ps);
    endfunction

    // Key columns are padded up to a whole number of col_width blocks.
    function automatic int calc_pk_depth(input int ps, input int cw);
        int k;
        int pad;
        k   = calc_k(ps);
        pad = (cw - (k % cw)) % cw;
        return (k + pad) * calc_l(ps) / cw;
    endfunction

    function automatic int calc_c_words(input int ps);
        return (calc_l(ps) + CIPHER_WORD_W - 1) / CIPHER_WORD_W;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/encrypt_seq_ctrl_skid.sv
// enc_skid2: two-entry 32-bit valid/ready buffer that absorbs ciphertext words
// returned by the core; the producer guarantees it never pushes into a full buffer.
module enc_skid2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic [1:0]  count
);

    logic [31:0] head_q;
    logic [31:0] tail_q;
    logic [1:0]  count_q;
    logic        pop;

    assign pop       = (count_q != 2'd0) && out_ready;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign count     = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= in_data;
                    else                 tail_q <= in_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push and pop keeps the occupancy unchanged.
                    if (count_q == 2'd1) begin
                        head_q <= in_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/encrypt_seq_ctrl.sv
// Sequencer for the column-block encryption core: launches the core, streams key
// blocks under arbiter grant, then drains ciphertext. Optional ENCRYPT_SEQ_CTRL_PERF_EN.
module encrypt_seq_ctrl
    import encrypt_seq_ctrl_pkg::*;
#(
    parameter  int parameter_set = 1,
    parameter  int col_width     = 128,
    localparam int PK_DEPTH      = calc_pk_depth(parameter_set, col_width),
    localparam int C_WORDS       = calc_c_words(parameter_set),
    localparam int PK_AW         = addr_width(PK_DEPTH),
    localparam int C_AW          = addr_width(C_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             err,
    input  logic             pk_grant,
    output logic             pk_rd_en,
    output logic [PK_AW-1:0] pk_addr,
    output logic             enc_start,
    input  logic             enc_K_ready,
    output logic             enc_K_col_valid,
    input  logic             enc_done,
    output logic             enc_rd_en_c,
    output logic [C_AW-1:0]  enc_addr_rd_c,
    input  logic [31:0]      enc_cipher,
    output logic [31:0]      c_data,
    output logic             c_valid,
    input  logic             c_ready,
    output logic             c_last,
    output logic [31:0]      perf_cycles
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [PK_AW-1:0] pk_addr_q;
    logic             col_valid_q;
    logic             err_q;
    logic [C_AW-1:0]  c_addr_q;
    logic             c_issue_done_q;
    logic             c_inflight_q;
    logic [C_AW-1:0]  c_out_idx_q;
    logic [1:0]       skid_count;
    logic             skid_valid;
    logic [31:0]      skid_data;

    logic start_accept;
    logic pk_issue;
    logic pk_last_issue;
    logic done_early;
    logic c_issue;
    logic c_xfer;
    logic c_final;

    assign start_accept  = (state == ST_IDLE) && start;
    assign pk_issue      = (state == ST_STREAM) && pk_grant;
    assign pk_last_issue = pk_issue && (pk_addr_q == PK_AW'(PK_DEPTH - 1));
    assign done_early    = (state == ST_STREAM) && enc_done;
    // Counting in-flight reads against buffer space means no returned word can be dropped.
    assign c_issue       = (state == ST_READOUT) && !c_issue_done_q &&
                           (({1'b0, skid_count} + {2'b00, c_inflight_q}) < 3'd2);
    assign c_xfer        = skid_valid && c_ready;
    assign c_final       = c_xfer && (c_out_idx_q == C_AW'(C_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        busy        = (state != ST_IDLE);
        enc_start   = (state == ST_LAUNCH);
        pk_rd_en    = pk_issue;
        enc_rd_en_c = c_issue;
        unique case (state)
            ST_IDLE:      if (start) state_next = ST_LAUNCH;
            ST_LAUNCH:    state_next = ST_WAIT_RDY;
            ST_WAIT_RDY:  if (enc_K_ready) state_next = ST_STREAM;
            ST_STREAM: begin
                if (enc_done)           state_next = ST_READOUT;
                else if (pk_last_issue) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: if (enc_done) state_next = ST_READOUT;
            ST_READOUT:   if (c_final) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Key stream address, column-valid strobe aligned with memory q, and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_addr_q   <= '0;
            col_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            col_valid_q <= pk_issue;
            if (done_early || pk_last_issue) pk_addr_q <= '0;
            else if (pk_issue)               pk_addr_q <= pk_addr_q + 1'b1;
            if (start_accept)    err_q <= 1'b0;
            else if (done_early) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_addr_q       <= '0;
            c_issue_done_q <= 1'b0;
            c_inflight_q   <= 1'b0;
            c_out_idx_q    <= '0;
        end else begin
            c_inflight_q <= c_issue;
            if (state == ST_IDLE) begin
                c_addr_q       <= '0;
                c_issue_done_q <= 1'b0;
                c_out_idx_q    <= '0;
            end else begin
                if (c_issue) begin
                    if (c_addr_q == C_AW'(C_WORDS - 1)) c_issue_done_q <= 1'b1;
                    else                                c_addr_q       <= c_addr_q + 1'b1;
                end
                if (c_xfer) c_out_idx_q <= c_out_idx_q + 1'b1;
            end
        end
    end

    enc_skid2 u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (c_inflight_q),
        .in_data   (enc_cipher),
        .out_valid (skid_valid),
        .out_data  (skid_data),
        .out_ready (c_ready),
        .count     (skid_count)
    );

    assign pk_addr         = pk_addr_q;
    assign enc_K_col_valid = col_valid_q;
    assign err             = err_q;
    assign enc_addr_rd_c   = c_addr_q;
    assign c_valid         = skid_valid;
    assign c_data          = skid_valid ? skid_data : 32'h0;
    assign c_last          = skid_valid && (c_out_idx_q == C_AW'(C_WORDS - 1));

`ifdef ENCRYPT_SEQ_CTRL_PERF_EN
    logic [31:0] perf_q;
    logic        perf_run_q;

    // Counts the accepted-start cycle through the cycle enc_done is seen, inclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q     <= '0;
            perf_run_q <= 1'b0;
        end else if (start_accept) begin
            perf_q     <= 32'd1;
            perf_run_q <= 1'b1;
        end else if (perf_run_q) begin
            if (perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
            if (enc_done && ((state == ST_STREAM) || (state == ST_WAIT_DONE)))
                perf_run_q <= 1'b0;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'h0;
`endif

endmodule

// File: doc/encrypt_seq_ctrl.md
Name: encrypt_seq_ctrl

Overview:
Sequencer for the column-block encryption core in encap. On a start request it launches the core and streams the sliced public key from single-port key memory as col_width-bit column blocks. It pauses whenever a shared-memory arbiter withdraws its grant. After the core reports done, it drains the l-bit ciphertext from the core's 32-bit read port as a backpressured valid/ready word stream.

Parameters:
parameter_set, 1, McEliece set selector (1..5)
n, 3488/4608/6688/6960/8192 by set, code length
m, 12 for set 1 else 13, field degree
t, 64/96/128/119/128 by set, error weight
col_width, 128, key column block width
l, m*t, syndrome/ciphertext length in bits
k, n-l, key columns
PK_DEPTH, (k+(col_width-k%col_width)%col_width)*l/col_width, key blocks to stream
C_WORDS, (l+31)/32, ciphertext words to read

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; ignored unless idle
busy  out  1  high from accepted start until last word taken
err  out  1  sticky; enc_done seen before all PK_DEPTH blocks issued; cleared by next accepted start
pk_grant  in  1  arbiter grant for key memory
pk_rd_en  out  1  key memory read strobe
pk_addr  out  CLOG2(PK_DEPTH)  key memory address
enc_start  out  1  one-cycle start pulse to core
enc_K_ready  in  1  core ready for key blocks
enc_K_col_valid  out  1  key block on memory q is valid
enc_done  in  1  core finished
enc_rd_en_c  out  1  ciphertext read strobe
enc_addr_rd_c  out  CLOG2(C_WORDS)  ciphertext word address
enc_cipher  in  32  ciphertext word, 1-cycle read latency
c_data  out  32  ciphertext stream data
c_valid  out  1  stream valid
c_ready  in  1  stream ready
c_last  out  1  marks word C_WORDS-1
perf_cycles  out  32  see Optional Feature

Behaviour:
- Reset, asynchronous on rst_n low, at any time including mid-operation: state IDLE, all outputs 0, counters 0, skid buffer empty.
- States: IDLE -> LAUNCH on start. LAUNCH: enc_start=1 for one cycle -> WAIT_RDY. WAIT_RDY: -> STREAM when enc_K_ready=1.
- STREAM: pk_rd_en=pk_grant; pk_addr increments on each issued read. Memory latency is 1 cycle: enc_K_col_valid equals pk_rd_en delayed one cycle, aligned with memory q.
- If pk_grant drops, no read is issued that cycle and enc_K_col_valid drops one cycle later. The core samples K_col only while valid, so gaps are legal.
- After read PK_DEPTH-1 is issued, go to WAIT_DONE. pk_addr returns to 0.
- WAIT_DONE: on enc_done go to READOUT. enc_done seen in STREAM: set err and go to READOUT immediately.
- READOUT: issue enc_rd_en_c with enc_addr_rd_c 0..C_WORDS-1. Returned words enter a 2-entry skid buffer. A read issues only if the buffer plus in-flight count is less than 2, so no word is ever dropped.
- c_valid=1 while the buffer is non-empty. A word transfers when c_valid and c_ready are both 1. c_last accompanies word C_WORDS-1.
- After the c_last transfer: busy=0, go to IDLE.
- start while busy is ignored, no queueing. start in the same cycle as the final transfer is also ignored.
- Counter widths are CLOG2 of depth. Counters never wrap mid-phase because terminal-count compares end each phase.

Optional Feature:
ENCRYPT_SEQ_CTRL_PERF_EN.
- Defined: perf_cycles counts clk cycles from the accepted start to the enc_done cycle inclusive, saturates at 2^32-1, holds until the next accepted start, and resets to 0.
- Undefined: perf_cycles is tied to 0 and no counter logic is built.

Decomposition:
- Shared package: parameter-set tables for n, m and t; derived l, k, PK_DEPTH and C_WORDS; state encoding constants.
- One sub-module, enc_skid2: 2-entry 32-bit valid/ready buffer with count output.

Test Plan:
- Set 1 (l=768, k=2720, PK_DEPTH=16896, C_WORDS=24), grant always high -> exactly 16896 valid pulses, addresses 0..16895 contiguous, 24 words out, c_last on word 23, err=0.
- Set 2 (PK_DEPTH=33696, C_WORDS=39), pk_grant low every 3rd cycle -> no duplicate or skipped address, valid count 33696, ciphertext matches golden output_sliced_2.
- c_ready toggled randomly, including 20 cycles low, during readout -> all 39 words in order, none lost, c_valid held stable while stalled.
- enc_done forced after 100 blocks -> err=1, readout still completes, err clears on next start.
- rst_n pulled low at block 5000 -> all outputs 0 asynchronously; fresh start then completes normally.
- start pulsed during STREAM -> ignored, one transaction only; with PERF_EN, perf_cycles equals the measured start-to-done cycle count.
